// File: rtl/pipeline_if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// instruction memory (slave). A request is held with a stable address until
// the memory answers with ack; ack may arrive in the same cycle as the request.
interface pipeline_if_stage_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pipeline_if_stage.sv
// Instruction fetch stage: issues fetches on the imem bus, presents one
// registered instruction per cycle to ID, parks a response in a one-entry
// hold buffer when ID stalls, and redirects on a flush from EX. A flush that
// lands while a request is still outstanding waits for (and drops) the old
// response before fetching the new target.
// Optional feature: define IF_MISALIGN_CHECK_EN to trap flushes to targets
// that are not 4-byte aligned in a FAULT state (misalign_IF=1). Without it
// the low two bits of redirect_pc are forced to zero.
module pipeline_if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [63:0]                redirect_pc,
    pipeline_if_stage_if.master        imem,
    output logic [31:0]                instruction_IF,
    output logic [63:0]                pc_IF,
    output logic                       valid_IF,
    output logic                       misalign_IF
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HOLD    = 3'd2,
        DISCARD = 3'd3
`ifdef IF_MISALIGN_CHECK_EN
        , FAULT = 3'd4
`endif
    } state_t;

    state_t      state_r, state_s;
    logic [63:0] fetch_pc_r, fetch_pc_s;
    logic [31:0] hold_inst_r, hold_inst_s;
    logic [63:0] hold_pc_r, hold_pc_s;
    logic [31:0] inst_r, inst_s;
    logic [63:0] pc_r, pc_s;
    logic        valid_r, valid_s;
    logic        req_r, req_s;
    logic [63:0] addr_r, addr_s;
    logic [63:0] target_s;
    logic [31:0] bub_inst_s;
    logic [63:0] bub_pc_s;
    logic        bub_valid_s;

`ifdef IF_MISALIGN_CHECK_EN
    logic        misalign_r, misalign_s;
    assign target_s    = redirect_pc;
    assign misalign_IF = misalign_r;
`else
    logic        unused_lsb_s;
    assign target_s     = {redirect_pc[63:2], 2'b00};
    assign unused_lsb_s = ^redirect_pc[1:0];
    assign misalign_IF  = 1'b0;
`endif

    // Output values for a cycle that delivers nothing: hold while stalled,
    // otherwise present a bubble.
    assign bub_inst_s  = stall ? inst_r : NOP_INST;
    assign bub_pc_s    = stall ? pc_r : 64'd0;
    assign bub_valid_s = stall & valid_r;

    // Next-state, fetch pointer, hold buffer and ID-facing output selection.
    always_comb begin
        state_s     = state_r;
        fetch_pc_s  = fetch_pc_r;
        hold_inst_s = hold_inst_r;
        hold_pc_s   = hold_pc_r;
        inst_s      = inst_r;
        pc_s        = pc_r;
        valid_s     = valid_r;
`ifdef IF_MISALIGN_CHECK_EN
        misalign_s  = misalign_r;
`endif
        if (flush) begin
            // Redirect wins over stall; any parked or returning data is stale.
            inst_s      = NOP_INST;
            pc_s        = 64'd0;
            valid_s     = 1'b0;
            fetch_pc_s  = target_s;
            hold_inst_s = NOP_INST;
            hold_pc_s   = 64'd0;
            if (((state_r == REQ) || (state_r == DISCARD)) && !imem.imem_ack) begin
                state_s = DISCARD;
            end else begin
                state_s = REQ;
            end
`ifdef IF_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_s    = FAULT;
                pc_s       = redirect_pc;
                misalign_s = 1'b1;
            end else begin
                misalign_s = 1'b0;
            end
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = REQ;
                    inst_s  = bub_inst_s;
                    pc_s    = bub_pc_s;
                    valid_s = bub_valid_s;
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        fetch_pc_s = fetch_pc_r + 64'd4;
                        if (stall) begin
                            hold_inst_s = imem.imem_rdata;
                            hold_pc_s   = fetch_pc_r;
                            state_s     = HOLD;
                        end else begin
                            inst_s  = imem.imem_rdata;
                            pc_s    = fetch_pc_r;
                            valid_s = 1'b1;
                        end
                    end else begin
                        inst_s  = bub_inst_s;
                        pc_s    = bub_pc_s;
                        valid_s = bub_valid_s;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_s  = hold_inst_r;
                        pc_s    = hold_pc_r;
                        valid_s = 1'b1;
                        state_s = REQ;
                    end else begin
                        state_s = HOLD;
                    end
                end
                DISCARD: begin
                    if (imem.imem_ack) begin
                        state_s = REQ;
                    end else begin
                        state_s = DISCARD;
                    end
                    inst_s  = bub_inst_s;
                    pc_s    = bub_pc_s;
                    valid_s = bub_valid_s;
                end
`ifdef IF_MISALIGN_CHECK_EN
                FAULT: begin
                    state_s = FAULT;
                end
`endif
                default: begin
                    state_s = IDLE;
                    inst_s  = NOP_INST;
                    pc_s    = 64'd0;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // Registered bus request: DISCARD keeps the old address outstanding while
    // fetch_pc already points at the redirect target.
    assign req_s = (state_s == REQ) || (state_s == DISCARD);
    assign addr_s = (state_s == DISCARD) ? addr_r : fetch_pc_s;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            fetch_pc_r  <= RESET_PC;
            hold_inst_r <= NOP_INST;
            hold_pc_r   <= 64'd0;
            inst_r      <= NOP_INST;
            pc_r        <= 64'd0;
            valid_r     <= 1'b0;
            req_r       <= 1'b0;
            addr_r      <= RESET_PC;
`ifdef IF_MISALIGN_CHECK_EN
            misalign_r  <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            fetch_pc_r  <= fetch_pc_s;
            hold_inst_r <= hold_inst_s;
            hold_pc_r   <= hold_pc_s;
            inst_r      <= inst_s;
            pc_r        <= pc_s;
            valid_r     <= valid_s;
            req_r       <= req_s;
            addr_r      <= addr_s;
`ifdef IF_MISALIGN_CHECK_EN
            misalign_r  <= misalign_s;
`endif
        end
    end

    assign imem.imem_req   = req_r;
    assign imem.imem_addr  = addr_r;
    assign instruction_IF  = inst_r;
    assign pc_IF           = pc_r;
    assign valid_IF        = valid_r;

endmodule
